// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider.
// One trial subtraction per clock; results and flags held in registers.
module div4_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] r, r_n;
    logic [WIDTH-1:0] q, q_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] quo_n, rem_n;
    logic             dbz_n;
    logic [WIDTH-1:0] r_sh, q_sh;
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            r           <= r_n;
            q           <= q_n;
            dvs         <= dvs_n;
            cnt         <= cnt_n;
            quotient    <= quo_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
        end
    end

    always_comb begin
        r_sh    = {r[WIDTH-2:0], q[WIDTH-1]};
        q_sh    = {q[WIDTH-2:0], 1'b0};
        trial   = {1'b0, r_sh} - {1'b0, dvs};
        state_n = state;
        r_n     = r;
        q_n     = q;
        dvs_n   = dvs;
        cnt_n   = cnt;
        quo_n   = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        dvs_n   = divisor;
                        r_n     = '0;
                        q_n     = dividend;
                        cnt_n   = '0;
                        state_n = RUN;
                    end else begin
                        quo_n   = '1;
                        rem_n   = dividend;
                        dbz_n   = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                // Borrow out of the trial means the subtraction is undone.
                r_n   = trial[WIDTH] ? r_sh : trial[WIDTH-1:0];
                q_n   = {q_sh[WIDTH-1:1], ~trial[WIDTH]};
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    quo_n   = q_n;
                    rem_n   = r_n;
                    dbz_n   = 1'b0;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div4_seq.sv
// Scoreboard bench for div4_seq: directed cases, sweep, random ops.
// Expected results come from plain integer division in the bench.
module tb_div4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        int q;
        int r;
        int z;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    div4_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int c);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.z = 1;
            e.cyc = c + 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 0;
            e.cyc = c + 1 + W;
        end
        return e;
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (busy && done) check("busy_and_done", 1, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", int'(quotient), e.q);
                    check("remainder", int'(remainder), e.r);
                    check("div_by_zero", int'(div_by_zero), e.z);
                    check("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issue at a negedge with busy=0; return at the negedge showing done.
    task automatic run_op(input int a, input int b);
        int nb;
        bit seen;
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        sb.push_back(model(a, b, cyc));
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 0, 1);
        check("busy_cycles", nb, (b == 0) ? 0 : W);
    endtask

    initial begin
        bit seen;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({busy, done, quotient, remainder, div_by_zero}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(13, 4);
        run_op(15, 1);
        run_op(3, 7);
        run_op(15, 15);
        run_op(9, 0);
        run_op(8, 2);
        @(negedge clk);

        // Start during busy must be ignored.
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        sb.push_back(model(13, 4, cyc));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("hold_quotient", int'(quotient), 3);
        check("hold_remainder", int'(remainder), 1);

        // Reset in the second RUN cycle aborts the operation.
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              int'({busy, done, quotient, remainder, div_by_zero}), 0);
        @(negedge clk);
        check("abort_no_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(14, 3);
        @(negedge clk);

        // Exhaustive back-to-back sweep.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op(a, b);

        // Random operations with random idle gaps.
        repeat (60) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        repeat (8) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
